// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: widths, FSM encoding and
// the fixed-priority grant decision.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int WORDS  = 8;
  localparam int OFF_W  = $clog2(WORDS);
  localparam int BLK_W  = ADDR_W - OFF_W - 1;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'b00;
  localparam arb_state_t ST_I_FILL  = 2'b01;
  localparam arb_state_t ST_D_FILL  = 2'b10;
  localparam arb_state_t ST_D_WRITE = 2'b11;

  // Store beats D-fill beats I-fill; returns ST_IDLE when nothing is pending.
  function automatic arb_state_t pick_grant(input logic wr_req,
                                            input logic d_req,
                                            input logic i_req);
    arb_state_t g;
    if (wr_req) begin
      g = ST_D_WRITE;
    end else if (d_req) begin
      g = ST_D_FILL;
    end else if (i_req) begin
      g = ST_I_FILL;
    end else begin
      g = ST_IDLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; master is the arbiter,
// slave is the surrounding system (caches plus memory).
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_miss_req;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss_req;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [ADDR_W-1:0] d_wr_data;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_valid;

  logic [ADDR_W-1:0] fill_data;
  logic [OFF_W-1:0]  fill_idx;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_done;
  logic              busy;

  modport master (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_data, fill_idx, i_fill_we, d_fill_we,
    output i_fill_done, d_fill_done, d_wr_done, busy
  );

  modport slave (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_data, fill_idx, i_fill_we, d_fill_we,
    input  i_fill_done, d_fill_done, d_wr_done, busy
  );

endinterface

// File: rtl/mem_arbiter_blk_fill_seq.sv
// Block-fill sequencer: issues WORDS consecutive reads of the latched block
// and counts returned words independently of memory latency.
module blk_fill_seq
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [BLK_W-1:0]  blk_i,
  input  logic              active_i,
  input  logic              mem_valid_i,
  output logic              issue_en_o,
  output logic [ADDR_W-1:0] issue_addr_o,
  output logic              recv_fire_o,
  output logic [OFF_W-1:0]  recv_idx_o,
  output logic              last_o
);

  localparam logic [OFF_W:0] WORDS_C = (OFF_W+1)'(WORDS);
  localparam logic [OFF_W:0] LAST_C  = (OFF_W+1)'(WORDS - 1);
  localparam logic [OFF_W:0] ONE_C   = (OFF_W+1)'(1);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [OFF_W:0]   issue_cnt_q, issue_cnt_d;
  logic [OFF_W:0]   recv_cnt_q, recv_cnt_d;

  // Issue/receive decode from the current counters.
  always_comb begin
    issue_en_o   = active_i && (issue_cnt_q < WORDS_C);
    issue_addr_o = {blk_q, issue_cnt_q[OFF_W-1:0], 1'b0};
    recv_fire_o  = active_i && mem_valid_i && (recv_cnt_q < WORDS_C);
    if (recv_fire_o) begin
      recv_idx_o = recv_cnt_q[OFF_W-1:0];
    end else begin
      recv_idx_o = {OFF_W{1'b0}};
    end
    last_o = recv_fire_o && (recv_cnt_q == LAST_C);
  end

  // Counter and block-address next state; a grant reloads everything.
  always_comb begin
    blk_d       = blk_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (start_i) begin
      blk_d       = blk_i;
      issue_cnt_d = {(OFF_W+1){1'b0}};
      recv_cnt_d  = {(OFF_W+1){1'b0}};
    end else begin
      if (issue_en_o) begin
        issue_cnt_d = issue_cnt_q + ONE_C;
      end else begin
        issue_cnt_d = issue_cnt_q;
      end
      if (recv_fire_o) begin
        recv_cnt_d = recv_cnt_q + ONE_C;
      end else begin
        recv_cnt_d = recv_cnt_q;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q       <= {BLK_W{1'b0}};
      issue_cnt_q <= {(OFF_W+1){1'b0}};
      recv_cnt_q  <= {(OFF_W+1){1'b0}};
    end else begin
      blk_q       <= blk_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Non-preemptive fixed-priority arbiter sharing one pipelined memory port
// between D-side stores, D-cache fills and I-cache fills.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  arb_state_t        grant_s;
  logic              start_s;
  logic              fill_active_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic [BLK_W-1:0]  grant_blk_s;

  logic              issue_en_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              recv_fire_s;
  logic [OFF_W-1:0]  recv_idx_s;
  logic              last_s;

  // Grant selection and the block address latched on entry.
  always_comb begin
    grant_s = pick_grant(bus.d_wr_req, bus.d_miss_req, bus.i_miss_req);
    case (grant_s)
      ST_D_WRITE: grant_addr_s = bus.d_wr_addr;
      ST_D_FILL:  grant_addr_s = bus.d_miss_addr;
      ST_I_FILL:  grant_addr_s = bus.i_miss_addr;
      default:    grant_addr_s = {ADDR_W{1'b0}};
    endcase
    grant_blk_s   = grant_addr_s[ADDR_W-1:OFF_W+1];
    start_s       = !rst && (state_q == ST_IDLE) && (grant_s != ST_IDLE);
    fill_active_s = !rst && ((state_q == ST_I_FILL) || (state_q == ST_D_FILL));
  end

  blk_fill_seq u_seq (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_s),
    .blk_i        (grant_blk_s),
    .active_i     (fill_active_s),
    .mem_valid_i  (bus.mem_valid),
    .issue_en_o   (issue_en_s),
    .issue_addr_o (issue_addr_s),
    .recv_fire_o  (recv_fire_s),
    .recv_idx_o   (recv_idx_s),
    .last_o       (last_s)
  );

  // FSM next state: a store lasts one cycle, a fill ends on its last word.
  always_comb begin
    case (state_q)
      ST_IDLE:    state_d = grant_s;
      ST_D_WRITE: state_d = ST_IDLE;
      ST_I_FILL,
      ST_D_FILL: begin
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output steering; held quiet during reset so an aborted fill cannot pulse done.
  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = {ADDR_W{1'b0}};
    bus.mem_wdata   = {ADDR_W{1'b0}};
    bus.fill_data   = bus.mem_rdata;
    bus.fill_idx    = {OFF_W{1'b0}};
    bus.i_fill_we   = 1'b0;
    bus.d_fill_we   = 1'b0;
    bus.i_fill_done = 1'b0;
    bus.d_fill_done = 1'b0;
    bus.d_wr_done   = 1'b0;
    bus.busy        = 1'b0;
    if (rst) begin
      bus.busy = 1'b0;
    end else begin
      bus.busy = (state_q != ST_IDLE);
      case (state_q)
        ST_D_WRITE: begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = bus.d_wr_addr;
          bus.mem_wdata = bus.d_wr_data;
          bus.d_wr_done = 1'b1;
        end
        ST_I_FILL,
        ST_D_FILL: begin
          bus.mem_en = issue_en_s;
          if (issue_en_s) begin
            bus.mem_addr = issue_addr_s;
          end else begin
            bus.mem_addr = {ADDR_W{1'b0}};
          end
          bus.fill_idx    = recv_idx_s;
          bus.i_fill_we   = (state_q == ST_I_FILL) && recv_fire_s;
          bus.d_fill_we   = (state_q == ST_D_FILL) && recv_fire_s;
          bus.i_fill_done = (state_q == ST_I_FILL) && last_s;
          bus.d_fill_done = (state_q == ST_D_FILL) && last_s;
        end
        default: begin
          bus.mem_en = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a transaction-level model and a latency-4 pipelined memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t pend[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model: 0 none, 1 I fill, 2 D fill, 3 store
  int         m_cur = 0;
  logic [11:0] m_blk = 12'h000;
  int         m_k = 0;
  int         m_recv = 0;

  logic        e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone, e_wdone, e_busy;
  logic [15:0] e_addr, e_wdata;
  logic [2:0]  e_idx;

  bit spur_en = 1'b0;
  bit force_spur = 1'b0;
  bit rand_req = 1'b0;

  int g_cyc = 0, idone_cyc = 0, ddone_cyc = 0, wdone_cyc = 0, idone_before = 0;
  logic [15:0] first_addr = 16'h0000, last_addr = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    bit we;
    @(negedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = pend[0].data;
      void'(pend.pop_front());
    end else if ((m_cur == 0 || m_cur == 3) &&
                 (force_spur || (spur_en && $urandom_range(0, 3) == 0))) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 16'($urandom);
    end else begin
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'($urandom);
    end
    #1;
    e_en = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_wdata = 16'h0000;
    e_iwe = 1'b0; e_dwe = 1'b0; e_idx = 3'd0;
    e_idone = 1'b0; e_ddone = 1'b0; e_wdone = 1'b0; e_busy = 1'b0;
    if (!rst && m_cur == 3) begin
      e_en = 1'b1; e_wr = 1'b1; e_addr = bus.d_wr_addr; e_wdata = bus.d_wr_data;
      e_wdone = 1'b1; e_busy = 1'b1;
    end else if (!rst && (m_cur == 1 || m_cur == 2)) begin
      e_busy = 1'b1;
      if (m_k <= WORDS) begin
        e_en = 1'b1;
        e_addr = {m_blk, 3'(m_k - 1), 1'b0};
      end
      we = (bus.mem_valid === 1'b1) && (m_recv < WORDS);
      e_idx = 3'(m_recv);
      if (m_cur == 1) begin
        e_iwe = we; e_idone = we && (m_recv == WORDS - 1);
      end else begin
        e_dwe = we; e_ddone = we && (m_recv == WORDS - 1);
      end
    end
    chk("mem_en",      32'(bus.mem_en),      32'(e_en));
    chk("mem_wr",      32'(bus.mem_wr),      32'(e_wr));
    chk("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
    chk("mem_wdata",   32'(bus.mem_wdata),   32'(e_wdata));
    chk("i_fill_we",   32'(bus.i_fill_we),   32'(e_iwe));
    chk("d_fill_we",   32'(bus.d_fill_we),   32'(e_dwe));
    chk("i_fill_done", 32'(bus.i_fill_done), 32'(e_idone));
    chk("d_fill_done", 32'(bus.d_fill_done), 32'(e_ddone));
    chk("d_wr_done",   32'(bus.d_wr_done),   32'(e_wdone));
    chk("busy",        32'(bus.busy),        32'(e_busy));
    chk("fill_data",   32'(bus.fill_data),   32'(bus.mem_rdata));
    if (e_iwe || e_dwe) chk("fill_idx", 32'(bus.fill_idx), 32'(e_idx));
    if (bus.i_fill_done === 1'b1) idone_cyc = cyc;
    if (bus.d_fill_done === 1'b1) ddone_cyc = cyc;
    if (bus.d_wr_done === 1'b1) wdone_cyc = cyc;
    if ((m_cur == 1 || m_cur == 2) && m_k == 1) first_addr = bus.mem_addr;
    if ((m_cur == 1 || m_cur == 2) && m_k == WORDS) last_addr = bus.mem_addr;
    if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0)
      pend.push_back('{due: cyc + LAT, data: 16'($urandom)});
    @(posedge clk);
    if (rst) begin
      m_cur = 0;
    end else if (m_cur == 0) begin
      if (bus.d_wr_req) begin
        m_cur = 3; g_cyc = cyc;
      end else if (bus.d_miss_req) begin
        m_cur = 2; m_blk = bus.d_miss_addr[15:4]; m_k = 1; m_recv = 0; g_cyc = cyc;
      end else if (bus.i_miss_req) begin
        m_cur = 1; m_blk = bus.i_miss_addr[15:4]; m_k = 1; m_recv = 0; g_cyc = cyc;
      end
    end else if (m_cur == 3) begin
      m_cur = 0;
    end else begin
      if (e_iwe || e_dwe) m_recv++;
      if (e_idone || e_ddone) m_cur = 0;
      else m_k++;
    end
    #1;
    if (e_idone) bus.i_miss_req = 1'b0;
    if (e_ddone) bus.d_miss_req = 1'b0;
    if (e_wdone) bus.d_wr_req = 1'b0;
    if (rand_req) begin
      if (!bus.i_miss_req && $urandom_range(0, 9) == 0) begin
        bus.i_miss_addr = 16'($urandom); bus.i_miss_req = 1'b1;
      end
      if (!bus.d_miss_req && $urandom_range(0, 9) == 0) begin
        bus.d_miss_addr = 16'($urandom); bus.d_miss_req = 1'b1;
      end
      if (!bus.d_wr_req && $urandom_range(0, 11) == 0) begin
        bus.d_wr_addr = 16'($urandom); bus.d_wr_data = 16'($urandom); bus.d_wr_req = 1'b1;
      end
    end
  endtask

  initial begin
    bus.i_miss_req = 1'b0; bus.i_miss_addr = 16'h0000;
    bus.d_miss_req = 1'b0; bus.d_miss_addr = 16'h0000;
    bus.d_wr_req = 1'b0;   bus.d_wr_addr = 16'h0000; bus.d_wr_data = 16'h0000;
    bus.mem_valid = 1'b0;  bus.mem_rdata = 16'h0000;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // I fill alone
    bus.i_miss_addr = 16'h1234; bus.i_miss_req = 1'b1;
    repeat (15) step();
    chk("A_done_latency", 32'(idone_cyc - g_cyc), 32'd12);
    chk("A_first_addr", 32'(first_addr), 32'h1230);
    chk("A_last_addr", 32'(last_addr), 32'h123E);

    // D fill wins over simultaneous I fill
    bus.d_miss_addr = 16'h4000; bus.d_miss_req = 1'b1;
    bus.i_miss_addr = 16'h0010; bus.i_miss_req = 1'b1;
    repeat (30) step();
    chk("B_i_after_d", 32'(idone_cyc - ddone_cyc), 32'd13);
    chk("B_i_first_addr", 32'(first_addr), 32'h0010);

    // Store arriving in I-fill cycle 3 waits for the fill
    bus.i_miss_addr = 16'h0800; bus.i_miss_req = 1'b1;
    step(); step(); step();
    bus.d_wr_addr = 16'h2002; bus.d_wr_data = 16'hBEEF; bus.d_wr_req = 1'b1;
    repeat (20) step();
    chk("C_wr_after_i", 32'(wdone_cyc - idone_cyc), 32'd2);

    // Store and D miss together: store first
    bus.d_wr_addr = 16'h3004; bus.d_wr_data = 16'h1357; bus.d_wr_req = 1'b1;
    bus.d_miss_addr = 16'h6100; bus.d_miss_req = 1'b1;
    repeat (20) step();
    chk("D_d_after_w", 32'(ddone_cyc - wdone_cyc), 32'd13);

    // Reset at fill cycle 6 aborts the fill
    bus.i_miss_addr = 16'h7770; bus.i_miss_req = 1'b1;
    repeat (6) step();
    idone_before = idone_cyc;
    rst = 1'b1; bus.i_miss_req = 1'b0;
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("E_no_done", 32'(idone_cyc), 32'(idone_before));
    bus.i_miss_addr = 16'h1A2B; bus.i_miss_req = 1'b1;
    repeat (14) step();
    chk("E_restart_latency", 32'(idone_cyc - g_cyc), 32'd12);
    chk("E_restart_first_addr", 32'(first_addr), 32'h1A20);

    // Spurious mem_valid in IDLE and right after the last word
    force_spur = 1'b1;
    repeat (3) step();
    force_spur = 1'b0;
    bus.i_miss_addr = 16'h2220; bus.i_miss_req = 1'b1;
    repeat (13) step();
    force_spur = 1'b1;
    step(); step();
    force_spur = 1'b0;
    chk("F_done_latency", 32'(idone_cyc - g_cyc), 32'd12);

    // Random traffic
    rand_req = 1'b1; spur_en = 1'b1;
    repeat (1500) step();
    rand_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_cur == 0 && !bus.i_miss_req && !bus.d_miss_req && !bus.d_wr_req) break;
      step();
    end
    chk("drain_idle", 32'((m_cur == 0) && !bus.i_miss_req && !bus.d_miss_req && !bus.d_wr_req), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
